icache_arb: RTL and testbench

Two-requester arbiter for the instruction cache read port in the fetch stage. Requester 0 is the instruction fetch queue (demand fetch); requester 1 is a secondary fetch source such as a next-line prefetcher or debug reader. The block grants at most one cache read per cycle using round-robin, tracks outstanding reads in order, and routes each returning line to its owner. Requester 0's in-flight reads are killed on a branch/jump redirect.

---
 rtl/icache_arb.sv | 121 ++++++++++++
 tb/tb_icache_arb.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/icache_arb.sv
`default_nettype none
// ============================================================================
// Module   : icache_arb
// Purpose  : Round-robin arbiter for two fetch sources sharing the I-cache read
//            port, with in-order response steering and redirect kill.
// Revision : 1.0
// ============================================================================
module icache_arb #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int MAX_OUT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              flush0,
    output logic              gnt0,
    output logic [LINE_W-1:0] dout0,
    output logic              dout0_valid,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic [LINE_W-1:0] dout1,
    output logic              dout1_valid,
    output logic [ADDR_W-1:0] Pc_in,
    output logic              Rd_en_cache,
    input  logic [LINE_W-1:0] Dout,
    input  logic              Dout_valid,
    output logic              err
);

    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    logic [MAX_OUT-1:0] owner_q, owner_d;
    logic [MAX_OUT-1:0] kill_q,  kill_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               rr_q, rr_d;
    logic               err_q, err_d;

    logic w_pop;
    logic w_accept;
    logic w_elig0;
    logic w_grant;
    logic w_win;
    logic w_head_owner;
    logic w_head_kill;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    // Outputs are gated by reset so that they read zero while reset is held.
    assign w_pop    = reset && Dout_valid && (count_q != '0);
    assign w_accept = (count_q < CNT_W'(MAX_OUT)) || Dout_valid;
    assign w_elig0  = req0 && !flush0;
    assign w_grant  = reset && w_accept && (w_elig0 || req1);
    assign w_win    = rr_q ? req1 : !w_elig0;

    assign gnt0        = w_grant && !w_win;
    assign gnt1        = w_grant && w_win;
    assign Rd_en_cache = w_grant;
    assign Pc_in       = w_grant ? (w_win ? addr1 : addr0) : '0;

    assign w_head_owner = owner_q[rd_ptr_q];
    assign w_head_kill  = kill_q[rd_ptr_q];

    // A flush in the pop cycle drops the head even though its kill bit is not yet set.
    assign dout0_valid = w_pop && !w_head_owner && !w_head_kill && !flush0;
    assign dout1_valid = w_pop && w_head_owner;
    assign dout0       = Dout;
    assign dout1       = Dout;
    assign err         = err_q;

    always_comb begin
        owner_d  = owner_q;
        kill_d   = kill_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rr_d     = rr_q;
        count_d  = count_q + CNT_W'(w_grant) - CNT_W'(w_pop);
        err_d    = err_q || (reset && Dout_valid && (count_q == '0));
        if (flush0) begin
            kill_d = kill_q | ~owner_q;
        end
        if (w_grant) begin
            owner_d[wr_ptr_q] = w_win;
            kill_d[wr_ptr_q]  = 1'b0;
            wr_ptr_d          = ptr_inc(wr_ptr_q);
            rr_d              = !w_win;
        end
        if (w_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q  <= '0;
            kill_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rr_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            owner_q  <= owner_d;
            kill_q   <= kill_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rr_q     <= rr_d;
            err_q    <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_arb
// Purpose  : Randomized bench for icache_arb against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_icache_arb;

    localparam int ADDR_W  = 32;
    localparam int LINE_W  = 128;
    localparam int MAX_OUT = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              req0 = 1'b0, req1 = 1'b0, flush0 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
    logic              gnt0, gnt1, dout0_valid, dout1_valid;
    logic [LINE_W-1:0] dout0, dout1;
    logic [ADDR_W-1:0] Pc_in;
    logic              Rd_en_cache, err;
    logic [LINE_W-1:0] Dout = '0;
    logic              Dout_valid = 1'b0;

    always #5 clk = ~clk;

    icache_arb #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0), .flush0(flush0), .gnt0(gnt0),
        .dout0(dout0), .dout0_valid(dout0_valid),
        .req1(req1), .addr1(addr1), .gnt1(gnt1),
        .dout1(dout1), .dout1_valid(dout1_valid),
        .Pc_in(Pc_in), .Rd_en_cache(Rd_en_cache),
        .Dout(Dout), .Dout_valid(Dout_valid), .err(err)
    );

    typedef struct packed {logic owner; logic kill;} ent_t;

    ent_t q[$];          // reads the arbiter should consider outstanding
    int   ready_q[$];    // cycle at which each issued read returns from the cache
    int   last_ready = 0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   rr_m = 0, err_m = 0;
    bit   granted0 = 0, granted1 = 0;
    bit   m_grant, m_win, m_pop, m_from_pending;

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_gnt0"}, gnt0, 0);
        chk({tag, "_gnt1"}, gnt1, 0);
        chk({tag, "_rd_en"}, Rd_en_cache, 0);
        chk({tag, "_pc_in"}, Pc_in, 0);
        chk({tag, "_dout0_valid"}, dout0_valid, 0);
        chk({tag, "_dout1_valid"}, dout1_valid, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic gen_inputs(input int req_pct);
        m_from_pending = (ready_q.size() > 0) && (ready_q[0] <= cyc);
        Dout_valid = m_from_pending ||
                     ((ready_q.size() == 0) && (q.size() == 0) && ($urandom % 30 == 0));
        Dout = {$urandom, $urandom, $urandom, $urandom};
        flush0 = ($urandom % 12 == 0);
        if (!req0 || granted0) begin
            req0  = ($urandom % 100) < req_pct;
            addr0 = $urandom;
        end
        if (flush0) begin
            req0  = 1'b1;
            addr0 = $urandom;
        end
        if (!req1 || granted1) begin
            req1  = ($urandom % 100) < req_pct;
            addr1 = $urandom;
        end
        granted0 = 0;
        granted1 = 0;
    endtask

    task automatic check_cycle();
        bit accept, e0, e1, v0, v1;
        logic [ADDR_W-1:0] pc;
        e0      = req0 && !flush0;
        e1      = req1;
        accept  = (q.size() < MAX_OUT) || Dout_valid;
        m_grant = accept && (e0 || e1);
        if (rr_m) m_win = e1 ? 1'b1 : 1'b0;
        else      m_win = e0 ? 1'b0 : 1'b1;
        m_pop = Dout_valid && (q.size() > 0);
        v0 = m_pop && !q[0].owner && !q[0].kill && !flush0;
        v1 = m_pop && q[0].owner;
        pc = !m_grant ? '0 : (m_win ? addr1 : addr0);
        chk("gnt0", gnt0, m_grant && !m_win);
        chk("gnt1", gnt1, m_grant && m_win);
        chk("rd_en", Rd_en_cache, m_grant);
        chk("pc_in", Pc_in, pc);
        chk("dout0_valid", dout0_valid, v0);
        chk("dout1_valid", dout1_valid, v1);
        chk("err", err, err_m);
        if (v0) chk("dout0", dout0, Dout);
        if (v1) chk("dout1", dout1, Dout);
    endtask

    task automatic update_model();
        int r;
        if (Dout_valid && q.size() == 0) err_m = 1;
        if (flush0) foreach (q[i]) if (!q[i].owner) q[i].kill = 1'b1;
        if (m_pop) void'(q.pop_front());
        if (m_from_pending) void'(ready_q.pop_front());
        if (m_grant) begin
            q.push_back('{owner: m_win, kill: 1'b0});
            r = cyc + int'($urandom_range(1, 4));
            if (r <= last_ready) r = last_ready + 1;
            ready_q.push_back(r);
            last_ready = r;
            rr_m = !m_win;
            if (m_win) granted1 = 1;
            else       granted0 = 1;
        end
    endtask

    task automatic reset_seq(input string tag);
        @(negedge clk);
        req0 = 1'b1; req1 = 1'b1; flush0 = 1'b0; Dout_valid = 1'b1;
        #2 reset = 1'b0;
        #1 check_zero({tag, "_a"});
        @(posedge clk);
        cyc++;
        @(negedge clk);
        #1 check_zero({tag, "_b"});
        #1 reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; Dout_valid = 1'b0;
        q.delete();
        rr_m = 0; err_m = 0; granted0 = 0; granted1 = 0;
        m_from_pending = 0;
        #1 check_cycle();
        @(posedge clk);
        update_model();
        cyc++;
    endtask

    initial begin
        reset_seq("reset_init");
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) reset_seq("reset_mid");
            @(negedge clk);
            gen_inputs((n >= 1000 && n < 1200) ? 10 : 70);
            #1 check_cycle();
            @(posedge clk);
            update_model();
            cyc++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
